// File: rtl/bcd_entry_packer_pkg.sv
// Shared display-interface types for the keypad entry path: packed BCD packet,
// glyph codes and the entry FSM states.
package bcd_entry_packer_pkg;

  // Six BCD nibbles; index 0 (bits [3:0]) is the newest digit.
  typedef logic [5:0][3:0] bcdPac_t;

  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hB;
  localparam bcdPac_t    BCD_ALL_BLANK = {6{BCD_BLANK}};

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } entry_state_t;

  function automatic bcdPac_t shift_in(bcdPac_t b, logic [3:0] d);
    return {b[4:0], d};
  endfunction

  function automatic bcdPac_t shift_out(bcdPac_t b);
    return {BCD_BLANK, b[5:1]};
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle counter: counts while run is high, restarts on clear,
// and flags the cycle in which it holds MAX-1.
module cycle_timer #(
  parameter int unsigned MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] r_cnt;

  assign expired = run && (r_cnt == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !run || expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_entry_packer.sv
// Keypad entry buffer feeding the display and the lock FSM.
// Optional build macro: MASK_DIGITS_EN (dash-mask held digits on the display).
module bcd_entry_packer
  import bcd_entry_packer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned MASK_CYCLES    = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        digit_del,
  input  logic        digit_clr,
  input  logic        digit_conf,
  output logic [23:0] bcd_packet,
  output logic        enable_o,
  output logic [2:0]  count,
  output logic [23:0] pin_out,
  output logic        pin_ready,
  output logic        timeout
);

  entry_state_t r_state, w_state_nxt;
  bcdPac_t      r_buf, w_buf_nxt;
  logic [2:0]   r_count, w_count_nxt;
  bcdPac_t      r_pin;
  logic         r_pin_ready, r_timeout, r_enable;

  logic w_digit_ok, w_accept, w_pin_load, w_timeout_set, w_reveal_restart;
  logic w_to_expired, w_hold_expired;

  // A digit only counts if no higher-priority strobe shares its cycle.
  assign w_digit_ok = digit_valid && (digit <= 4'd9) &&
                      !digit_clr && !digit_conf && !digit_del;

  cycle_timer #(.MAX(TIMEOUT_CYCLES)) u_timeout_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept),
    .run     (r_state == ENTRY),
    .expired (w_to_expired)
  );

  cycle_timer #(.MAX(HOLD_CYCLES)) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_pin_load),
    .run     (r_state == HOLD),
    .expired (w_hold_expired)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_buf_nxt        = r_buf;
    w_count_nxt      = r_count;
    w_accept         = 1'b0;
    w_pin_load       = 1'b0;
    w_timeout_set    = 1'b0;
    w_reveal_restart = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_digit_ok) begin
          w_buf_nxt        = shift_in(r_buf, digit);
          w_count_nxt      = r_count + 3'd1;
          w_state_nxt      = ENTRY;
          w_accept         = 1'b1;
          w_reveal_restart = 1'b1;
        end
      end
      ENTRY: begin
        if (digit_clr) begin
          w_buf_nxt   = BCD_ALL_BLANK;
          w_count_nxt = 3'd0;
          w_state_nxt = IDLE;
          w_accept    = 1'b1;
        end else if (digit_conf) begin
          if (r_count != 3'd0) begin
            w_pin_load  = 1'b1;
            w_state_nxt = HOLD;
            w_accept    = 1'b1;
          end
        end else if (digit_del) begin
          if (r_count != 3'd0) begin
            w_buf_nxt        = shift_out(r_buf);
            w_count_nxt      = r_count - 3'd1;
            w_accept         = 1'b1;
            w_reveal_restart = 1'b1;
            if (r_count == 3'd1) w_state_nxt = IDLE;
          end
        end else if (w_digit_ok && (r_count < 3'd6)) begin
          w_buf_nxt        = shift_in(r_buf, digit);
          w_count_nxt      = r_count + 3'd1;
          w_accept         = 1'b1;
          w_reveal_restart = 1'b1;
        end else if (w_to_expired) begin
          w_buf_nxt     = BCD_ALL_BLANK;
          w_count_nxt   = 3'd0;
          w_state_nxt   = IDLE;
          w_timeout_set = 1'b1;
        end
      end
      HOLD: begin
        if (w_hold_expired) begin
          w_buf_nxt   = BCD_ALL_BLANK;
          w_count_nxt = 3'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= BCD_ALL_BLANK;
      r_count     <= 3'd0;
      r_pin       <= BCD_ALL_BLANK;
      r_pin_ready <= 1'b0;
      r_timeout   <= 1'b0;
      r_enable    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_count     <= w_count_nxt;
      r_pin_ready <= w_pin_load;
      r_timeout   <= w_timeout_set;
      r_enable    <= (w_state_nxt != IDLE);
      if (w_pin_load) r_pin <= r_buf;
    end
  end

  assign enable_o  = r_enable;
  assign count     = r_count;
  assign pin_out   = r_pin;
  assign pin_ready = r_pin_ready;
  assign timeout   = r_timeout;

`ifdef MASK_DIGITS_EN
  logic    r_reveal, w_mask_expired;
  bcdPac_t w_disp;

  cycle_timer #(.MAX(MASK_CYCLES)) u_mask_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_reveal_restart),
    .run     (r_state == ENTRY),
    .expired (w_mask_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reveal <= 1'b0;
    end else if (w_reveal_restart) begin
      r_reveal <= 1'b1;
    end else if (w_mask_expired || (r_state != ENTRY)) begin
      r_reveal <= 1'b0;
    end
  end

  // Held digits are never BLANK, so blanks pass through unmasked.
  always_comb begin
    w_disp = r_buf;
    for (int unsigned i = 0; i < 6; i++) begin
      if ((r_buf[i] != BCD_BLANK) && !((i == 0) && r_reveal && (r_state == ENTRY))) begin
        w_disp[i] = BCD_DASH;
      end
    end
  end

  assign bcd_packet = w_disp;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^MASK_CYCLES;
  assign bcd_packet    = r_buf;
`endif

endmodule
